evac_prio_queue: RTL and testbench
==================================

Name: evac_prio_queue

Overview:
- Parametrised successor to the 4-entry evacuation FIFO.
- Stores (zone, priority) evacuation requests, up to DEPTH deep.
- Serves the highest-priority pending request first; ties among equal priorities are served oldest-first.
- Adds what the FIFO lacked:
  - full flag and occupancy count;
  - overflow and underflow error pulses;
  - defined insert+serve in the same cycle;
  - a working synchronous clear.
- Sits between the zone-request front end and the dispatch controller.

Parameters:
- DEPTH, 8: number of entries; integer ≥ 2.
- ZONE_W, 8: zone identifier width.
- PRIO_W, 2: priority width; larger value means more urgent.
- CNT_W, $clog2(DEPTH+1): width of the count port.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- insert  in  1  enqueue zone_in/prio_in this cycle.
- serve  in  1  dequeue the currently presented entry this cycle.
- clear  in  1  synchronous flush of all entries.
- zone_in  in  ZONE_W  zone of the request being inserted.
- prio_in  in  PRIO_W  priority of the request being inserted.
- out_zone  out  ZONE_W  zone of the selected (next-to-serve) entry; 0 when empty.
- out_prio  out  PRIO_W  priority of the selected entry; 0 when empty.
- out_valid  out  1  high when an entry is presented (equals !empty).
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  CNT_W  number of stored entries.
- overflow  out  1  registered one-cycle pulse: insert was dropped.
- underflow  out  1  registered one-cycle pulse: serve was ignored.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all valid bits, storage, count, overflow and underflow go to 0;
  - empty = 1, full = 0, out_valid = 0, out_zone = 0, out_prio = 0.
- Storage is an insertion-ordered array, slot 0 oldest, with slots 0..count-1 occupied; it is kept compacted (no holes).
- Selection (combinational from registered state, show-ahead, zero latency):
  - sel = lowest index i < count whose prio is the maximum prio among occupied slots;
  - out_zone/out_prio = slot[sel], or 0 when empty.
- Serve (serve=1, not empty, clear=0):
  - slot[sel] is removed; slots sel+1..count-1 shift down by one.
  - New outputs are visible the cycle after the edge.
- Insert (insert=1, clear=0):
  - Accepted when not full, or when full and a valid serve occurs in the same cycle.
  - The new entry is written at slot (count − 1 if a serve is also accepted, else count), after compaction.
- Count update:
  - +1 on insert-only;
  - −1 on serve-only;
  - unchanged when both are accepted.
- Insert while full without serve: entry dropped, state unchanged, overflow=1 for one cycle.
- Serve while empty: ignored, underflow=1 for one cycle. An insert in the same cycle is still accepted (count 0→1).
- Insert+serve with count==1:
  - the old entry is removed and the new entry is stored in slot 0;
  - count stays 1.
- Clear:
  - takes precedence over insert/serve;
  - next cycle count=0 and all valid bits are 0; stored data need not be zeroed;
  - no overflow or underflow pulse is raised in a clear cycle.
- Error pulses are registered and deassert the following cycle unless the error condition repeats.
- Reset asserted mid-operation: immediate return to reset state; no partial shift survives.
- Priority ties: strict FIFO among equal priorities. Lower priorities may starve (no aging in this generation).
- count, empty and full are all derived from the same registered counter; they are never inconsistent.

Test Plan:
- DEPTH=4. Insert (0x11,p1),(0x22,p3),(0x33,p1),(0x44,p3) -> count=4, full=1, out_zone=0x22. Serving 4 times yields 0x22, 0x44, 0x11, 0x33; then empty=1, out_zone=0.
- Full queue; insert (0x55,p0) alone -> overflow pulses 1 cycle, count stays 4, contents unchanged. Then insert (0x55,p0)+serve -> 0x22 removed, count=4, 0x55 is last to be served.
- Empty queue; serve -> underflow pulse, count=0. Serve+insert (0x66,p2) -> underflow pulse, count=1, out_zone=0x66, out_prio=2.
- Count=1 holding (0x77,p0); insert (0x88,p3)+serve same cycle -> count=1, out_zone=0x88, out_prio=3, no error pulses.
- Count=3; clear with insert and serve also high -> next cycle count=0, empty=1, no overflow/underflow. A subsequent insert (0x99,p1) gives count=1, out_zone=0x99.
- Count=3; assert rst_n=0 mid-cycle -> outputs zero immediately and asynchronously. After release, empty=1 and the first insert lands in slot 0.

Source files
------------

// File: rtl/evac_prio_queue.sv
// Priority queue of (zone, priority) evacuation requests: highest priority first,
// oldest first among equal priorities. Storage is insertion-ordered and kept compacted.
module evac_prio_queue #(
    parameter int DEPTH  = 8,
    parameter int ZONE_W = 8,
    parameter int PRIO_W = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              insert,
    input  logic              serve,
    input  logic              clear,
    input  logic [ZONE_W-1:0] zone_in,
    input  logic [PRIO_W-1:0] prio_in,
    output logic [ZONE_W-1:0] out_zone,
    output logic [PRIO_W-1:0] out_prio,
    output logic              out_valid,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ZONE_W-1:0] zone_reg  [DEPTH];
    logic [ZONE_W-1:0] zone_next [DEPTH];
    logic [PRIO_W-1:0] prio_reg  [DEPTH];
    logic [PRIO_W-1:0] prio_next [DEPTH];
    logic [DEPTH-1:0]  valid_reg;
    logic [DEPTH-1:0]  valid_next;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W-1:0]  wr_idx;
    logic              overflow_reg;
    logic              underflow_reg;
    logic [IDX_W-1:0]  sel;
    logic [PRIO_W-1:0] best_prio;
    logic              is_empty;
    logic              is_full;
    logic              serve_ok;
    logic              insert_ok;

    assign is_empty  = (count_reg == '0);
    assign is_full   = (count_reg == CNT_W'(DEPTH));
    assign serve_ok  = serve && !clear && !is_empty;
    assign insert_ok = insert && !clear && (!is_full || serve_ok);
    // A same-cycle serve compacts first, so the new entry lands one slot lower.
    assign wr_idx    = serve_ok ? (count_reg - 1'b1) : count_reg;

    // Strict '>' keeps the oldest slot among equal maximum priorities.
    always_comb begin
        sel       = '0;
        best_prio = prio_reg[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (valid_reg[i] && (prio_reg[i] > best_prio)) begin
                sel       = IDX_W'(i);
                best_prio = prio_reg[i];
            end
        end
    end

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (insert_ok && !serve_ok) begin
            count_next = count_reg + 1'b1;
        end else if (serve_ok && !insert_ok) begin
            count_next = count_reg - 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [ZONE_W-1:0] zone_src;
            logic [PRIO_W-1:0] prio_src;
            logic              write_here;

            if (gi < DEPTH - 1) begin : g_shift
                assign zone_src = (serve_ok && (IDX_W'(gi) >= sel)) ? zone_reg[gi+1] : zone_reg[gi];
                assign prio_src = (serve_ok && (IDX_W'(gi) >= sel)) ? prio_reg[gi+1] : prio_reg[gi];
            end else begin : g_last
                assign zone_src = zone_reg[gi];
                assign prio_src = prio_reg[gi];
            end

            assign write_here     = insert_ok && (wr_idx == CNT_W'(gi));
            assign zone_next[gi]  = write_here ? zone_in : zone_src;
            assign prio_next[gi]  = write_here ? prio_in : prio_src;
            assign valid_next[gi] = (CNT_W'(gi) < count_next);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg     <= '0;
            valid_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                zone_reg[i] <= '0;
                prio_reg[i] <= '0;
            end
        end else begin
            count_reg     <= count_next;
            valid_reg     <= valid_next;
            overflow_reg  <= insert && !clear && is_full && !serve_ok;
            underflow_reg <= serve && !clear && is_empty;
            for (int i = 0; i < DEPTH; i++) begin
                zone_reg[i] <= zone_next[i];
                prio_reg[i] <= prio_next[i];
            end
        end
    end

    assign out_zone  = is_empty ? '0 : zone_reg[sel];
    assign out_prio  = is_empty ? '0 : prio_reg[sel];
    assign out_valid = !is_empty;
    assign empty     = is_empty;
    assign full      = is_full;
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
endmodule

// File: tb/tb_evac_prio_queue.sv
// Randomised plus directed bench for evac_prio_queue; a queue-based reference model
// feeds a scoreboard that a separate monitor drains once per clock.
module tb_evac_prio_queue;
    localparam int DEPTH  = 4;
    localparam int ZONE_W = 8;
    localparam int PRIO_W = 2;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              insert = 1'b0;
    logic              serve = 1'b0;
    logic              clear = 1'b0;
    logic [ZONE_W-1:0] zone_in = '0;
    logic [PRIO_W-1:0] prio_in = '0;
    logic [ZONE_W-1:0] out_zone;
    logic [PRIO_W-1:0] out_prio;
    logic              out_valid;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    evac_prio_queue #(.DEPTH(DEPTH), .ZONE_W(ZONE_W), .PRIO_W(PRIO_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .insert(insert), .serve(serve), .clear(clear),
        .zone_in(zone_in), .prio_in(prio_in), .out_zone(out_zone), .out_prio(out_prio),
        .out_valid(out_valid), .empty(empty), .full(full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct { int zone; int prio; } ent_t;
    typedef struct { int cyc; int zone; int prio; int cnt; int ovf; int unf; } exp_t;

    ent_t mq[$];
    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Next-to-serve = earliest request holding the highest priority.
    function automatic int model_sel();
        int best = 0;
        for (int i = 1; i < mq.size(); i++)
            if (mq[i].prio > mq[best].prio) best = i;
        return best;
    endfunction

    task automatic step(input bit ins, input bit srv, input bit clr, input int z, input int p);
        exp_t e;
        ent_t n;
        bit   srv_ok;
        @(posedge clk);
        #1;
        insert  = ins;
        serve   = srv;
        clear   = clr;
        zone_in = ZONE_W'(z);
        prio_in = PRIO_W'(p);
        e.ovf = 0;
        e.unf = 0;
        if (clr) begin
            mq.delete();
        end else begin
            srv_ok = srv && (mq.size() > 0);
            if (srv && mq.size() == 0) e.unf = 1;
            if (ins && !(mq.size() < DEPTH || srv_ok)) e.ovf = 1;
            if (ins && (mq.size() < DEPTH || srv_ok)) begin
                if (srv_ok) mq.delete(model_sel());
                n.zone = z;
                n.prio = p;
                mq.push_back(n);
            end else if (srv_ok) begin
                mq.delete(model_sel());
            end
        end
        e.cyc  = cyc + 1;
        e.cnt  = mq.size();
        e.zone = (mq.size() == 0) ? 0 : mq[model_sel()].zone;
        e.prio = (mq.size() == 0) ? 0 : mq[model_sel()].prio;
        sb.push_back(e);
    endtask

    task automatic idle_drain();
        step(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            $display("cyc %0d: zone=%h prio=%0d count=%0d ovf=%0b unf=%0b", cyc, out_zone, out_prio,
                     count, overflow, underflow);
            chk("out_zone", int'(out_zone), e.zone);
            chk("out_prio", int'(out_prio), e.prio);
            chk("count", int'(count), e.cnt);
            chk("empty", int'(empty), int'(e.cnt == 0));
            chk("full", int'(full), int'(e.cnt == DEPTH));
            chk("out_valid", int'(out_valid), int'(e.cnt != 0));
            chk("overflow", int'(overflow), e.ovf);
            chk("underflow", int'(underflow), e.unf);
        end
    end

    task automatic check_zero_state(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_zone"}, int'(out_zone), 0);
        chk({tag, "_prio"}, int'(out_prio), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
        chk({tag, "_unf"}, int'(underflow), 0);
    endtask

    initial begin
        #2;
        check_zero_state("reset");
        #10;
        rst_n = 1'b1;

        // Ordering: p3 entries first (oldest first), then p1 entries.
        step(1, 0, 0, 'h11, 1);
        step(1, 0, 0, 'h22, 3);
        step(1, 0, 0, 'h33, 1);
        step(1, 0, 0, 'h44, 3);
        repeat (4) step(0, 1, 0, 0, 0);

        // Overflow, then insert+serve while full.
        step(1, 0, 0, 'h11, 1);
        step(1, 0, 0, 'h22, 3);
        step(1, 0, 0, 'h33, 1);
        step(1, 0, 0, 'h44, 3);
        step(1, 0, 0, 'h55, 0);
        step(1, 1, 0, 'h55, 0);
        repeat (4) step(0, 1, 0, 0, 0);

        // Underflow, alone and with an insert.
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 'h66, 2);
        step(0, 1, 0, 0, 0);

        // Insert+serve with a single stored entry.
        step(1, 0, 0, 'h77, 0);
        step(1, 1, 0, 'h88, 3);
        step(0, 1, 0, 0, 0);

        // Clear wins over insert and serve.
        step(1, 0, 0, 'h01, 1);
        step(1, 0, 0, 'h02, 2);
        step(1, 0, 0, 'h03, 0);
        step(1, 1, 1, 'h04, 3);
        step(1, 0, 0, 'h99, 1);

        // Asynchronous reset mid-cycle with three entries stored.
        step(1, 0, 0, 'hA1, 2);
        step(1, 0, 0, 'hA2, 1);
        idle_drain();
        chk("pre_reset_count", int'(count), 3);
        rst_n = 1'b0;
        #1;
        check_zero_state("async_rst");
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 'hAA, 2);
        step(0, 1, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 4), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 3)));
        end
        idle_drain();
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
